pe_credit_tx_sched: RTL and testbench
=====================================

// Module: pe_credit_tx_sched
// PURPOSE
//  Credit-gated, packet-granular scheduler between the two PE output streams (0: cast/gather, 1: merge)
//  and one router injection port. Round-robin between requesters; a grant is held for one whole
//  packet (wormhole). Each flit consumes one downstream receive-buffer credit; credits are returned
//  on the receiver's 32-bit credit-update bus. Watchdog flags suspected deadlock in whole-network sims.
// PARAMETERS
//  CREDIT_MAX  16    downstream receive-buffer depth in flits; credit counter reset value
//  PKT_LEN     4     flits per packet (>=1); lock is released after flit PKT_LEN-1
//  WDOG        1024  consecutive stalled cycles (valid pending, zero credits) before stall_o
//  x, y        0     node coordinates, used only in $display messages
//  CW = $clog2(CREDIT_MAX+1) localparam; data width is `DW
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous reset, active-high
//  req0_data_i    in   `DW    cast/gather stream flit
//  req0_valid_i   in   1      stream 0 valid
//  req0_ready_o   out  1      stream 0 ready
//  req1_data_i    in   `DW    merge stream flit
//  req1_valid_i   in   1      stream 1 valid
//  req1_ready_o   out  1      stream 1 ready
//  data_o         out  `DW    flit to router
//  valid_o        out  1      flit valid
//  ready_i        in   1      router accepts
//  credit_upd_i   in   32     credits returned this cycle (unsigned count)
//  credits_o      out  CW     current credit count
//  owner_o        out  1      requester holding the grant (meaningful in LOCKED)
//  stall_o        out  1      sticky: watchdog expired
//  err_o          out  1      sticky: credit overflow (count would exceed CREDIT_MAX)
// BEHAVIOUR
//  Reset: state=IDLE, credits=CREDIT_MAX, rr_ptr=0, flit_cnt=0, wdog_cnt=0, stall_o=0, err_o=0,
//   owner=0. Outputs are combinational from state; valid_o=0 and both ready_o=0 while rst=1.
//  FSM IDLE: if any reqN_valid_i, grant via rr_ptr priority (rr_ptr=0 -> req0 first);
//   owner<=winner, state<=LOCKED next cycle (1-cycle grant latency). No flit moves in IDLE.
//  FSM LOCKED: valid_o = req[owner].valid & (credits!=0); data_o = req[owner].data;
//   req[owner].ready_o = ready_i & (credits!=0); non-owner ready_o=0. xfer = valid_o & ready_i.
//   On xfer: flit_cnt++; if flit_cnt==PKT_LEN-1: flit_cnt<=0, rr_ptr<=~owner, state<=IDLE
//   (one bubble cycle between packets). Owner valid may drop mid-packet; the lock is held.
//  Credits: next = credits - xfer + credit_upd_i, computed at 33 bits. If the result exceeds
//   CREDIT_MAX: clamp to CREDIT_MAX, set err_o. Decrement and return in the same cycle net out.
//   xfer never occurs at credits==0, so no underflow.
//  Watchdog: in LOCKED with req[owner].valid & credits==0, wdog_cnt++, else wdog_cnt<=0.
//   At wdog_cnt==WDOG-1: stall_o<=1 and $display("time %0t: node (%0d, %0d) stalled on credits").
//  Ready low with credits>0 does not count toward the watchdog (router backpressure, not credits).
//  Reset mid-packet: abandon packet, all state returns to reset values next edge; no flit emitted.
// STRUCTURE
//  Shared package: sched_state_e {IDLE, LOCKED} and CREDIT_MAX/PKT_LEN defaults.
//  One sub-module: credit_counter (saturating up/down counter, CW bits, err flag); rest inline.
// TESTING
//  1 Reset: credits_o=16, valid_o=0, stall_o=0, err_o=0, both ready_o=0.
//  2 req0 holds 4 flits, ready_i=1, no credit return -> grant 1 cycle later, 4 flits back-to-back,
//    credits 16->12, IDLE one cycle, rr_ptr=1.
//  3 req0 and req1 valid continuously -> packets alternate 0,1,0,1; never two flits from different
//    owners within one packet.
//  4 Drain to 0 credits -> valid_o=0 and ready_o=0; credit_upd_i=1 in a cycle -> next cycle one flit
//    sent; same-cycle xfer with credit_upd_i=1 leaves credits unchanged.
//  5 credits=16 plus credit_upd_i=3 -> credits stay 16, err_o=1 sticky.
//  6 WDOG=8, credits 0, owner valid 8 cycles -> stall_o=1; rst mid-packet -> IDLE, credits=16.

Source files
------------

// File: rtl/pe_credit_tx_sched_pkg.sv
// Shared types and defaults for the PE credit-gated injection scheduler.
`ifndef DW
`define DW 32
`endif

package pe_credit_tx_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    localparam int unsigned CREDIT_MAX_DEF = 16;
    localparam int unsigned PKT_LEN_DEF    = 4;
    localparam int unsigned WDOG_DEF       = 1024;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_credit_tx_sched_credit_counter.sv
// Downstream credit counter: one credit per sent flit, bulk returns, clamps at CREDIT_MAX with sticky error.
module pe_credit_tx_sched_credit_counter
    import pe_credit_tx_sched_pkg::*;
#(
    parameter  int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
    localparam int unsigned CW         = $clog2(CREDIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_i,
    input  logic [31:0]   inc_i,
    output logic [CW-1:0] count_o,
    output logic          err_o
);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [32:0]   sum;

    // Wide sum so that a huge return value cannot wrap back into range.
    always_comb begin
        sum     = {1'b0, inc_i} + 33'(count_q) - 33'(dec_i);
        count_d = sum[CW-1:0];
        err_d   = err_q;
        if (sum > 33'(CREDIT_MAX)) begin
            count_d = CW'(CREDIT_MAX);
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(CREDIT_MAX);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/pe_credit_tx_sched.sv
// Packet-granular round-robin scheduler of two PE streams onto one credit-gated router injection port.
module pe_credit_tx_sched
    import pe_credit_tx_sched_pkg::*;
#(
    parameter  int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
    parameter  int unsigned PKT_LEN    = PKT_LEN_DEF,
    parameter  int unsigned WDOG       = WDOG_DEF,
    parameter  int          x          = 0,
    parameter  int          y          = 0,
    localparam int unsigned CW         = $clog2(CREDIT_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [`DW-1:0] req0_data_i,
    input  logic           req0_valid_i,
    output logic           req0_ready_o,
    input  logic [`DW-1:0] req1_data_i,
    input  logic           req1_valid_i,
    output logic           req1_ready_o,
    output logic [`DW-1:0] data_o,
    output logic           valid_o,
    input  logic           ready_i,
    input  logic [31:0]    credit_upd_i,
    output logic [CW-1:0]  credits_o,
    output logic           owner_o,
    output logic           stall_o,
    output logic           err_o
);

    localparam int unsigned FW = cnt_width(PKT_LEN);
    localparam int unsigned WW = cnt_width(WDOG);

    sched_state_e  state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [FW-1:0] flit_q, flit_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          stall_q, stall_d;

    logic           own_valid;
    logic [`DW-1:0] own_data;
    logic           has_credit;
    logic           xfer;
    logic           starved;

    assign own_valid  = owner_q ? req1_valid_i : req0_valid_i;
    assign own_data   = owner_q ? req1_data_i  : req0_data_i;
    assign has_credit = (credits_o != '0);
    assign xfer       = valid_o & ready_i;
    assign starved    = (state_q == LOCKED) && own_valid && !has_credit;

    pe_credit_tx_sched_credit_counter #(
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit_counter (
        .clk     (clk),
        .rst     (rst),
        .dec_i   (xfer),
        .inc_i   (credit_upd_i),
        .count_o (credits_o),
        .err_o   (err_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            flit_q  <= '0;
            wdog_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            flit_q  <= flit_d;
            wdog_q  <= wdog_d;
            stall_q <= stall_d;
        end
    end

    // The grant is held until the last flit of the packet leaves, even if the owner's valid drops.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        flit_d  = flit_q;
        wdog_d  = '0;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    state_d = LOCKED;
                    if (rr_q == 1'b0) owner_d = req0_valid_i ? 1'b0 : 1'b1;
                    else              owner_d = req1_valid_i ? 1'b1 : 1'b0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (flit_q == FW'(PKT_LEN - 1)) begin
                        flit_d  = '0;
                        rr_d    = ~owner_q;
                        state_d = IDLE;
                    end else begin
                        flit_d = flit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (starved) begin
            if (wdog_q == WW'(WDOG - 1)) begin
                stall_d = 1'b1;
                wdog_d  = wdog_q;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_o      = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        data_o       = own_data;
        if (!rst && state_q == LOCKED) begin
            valid_o      = own_valid & has_credit;
            req0_ready_o = ~owner_q & ready_i & has_credit;
            req1_ready_o =  owner_q & ready_i & has_credit;
        end
    end

    assign owner_o = owner_q;
    assign stall_o = stall_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && starved && !stall_q && wdog_q == WW'(WDOG - 1))
            $display("time %0t: node (%0d, %0d) stalled on credits", $time, x, y);
    end
`endif

endmodule

// File: tb/tb_pe_credit_tx_sched.sv
// Directed bench for pe_credit_tx_sched: grant latency, round robin, credit gating, watchdog, overflow.
`ifndef DW
`define DW 32
`endif

module tb_pe_credit_tx_sched;

    logic           clk = 1'b0;
    logic           rst;
    logic [`DW-1:0] req0Data, req1Data, dataOut;
    logic           req0Valid, req1Valid, req0Ready, req1Ready;
    logic           validOut, readyIn;
    logic [31:0]    creditUpd;
    logic [4:0]     credits;
    logic           owner, stall, err;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    pe_credit_tx_sched #(
        .CREDIT_MAX (16),
        .PKT_LEN    (4),
        .WDOG       (8),
        .x          (1),
        .y          (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_data_i  (req0Data),
        .req0_valid_i (req0Valid),
        .req0_ready_o (req0Ready),
        .req1_data_i  (req1Data),
        .req1_valid_i (req1Valid),
        .req1_ready_o (req1Ready),
        .data_o       (dataOut),
        .valid_o      (validOut),
        .ready_i      (readyIn),
        .credit_upd_i (creditUpd),
        .credits_o    (credits),
        .owner_o      (owner),
        .stall_o      (stall),
        .err_o        (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0Valid = 1'b1; req1Valid = 1'b1; readyIn = 1'b1; creditUpd = '0;
        req0Data = '0; req1Data = '0;
        tick; tick;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd16) begin testsFailed++; $display("[TB] FAIL reset_credits: got %0d want 16", credits); end
        testsRun++;
        if ({validOut, req0Ready, req1Ready} !== 3'b000) begin
            testsFailed++; $display("[TB] FAIL reset_handshake: got valid/rdy0/rdy1=%b want 000", {validOut, req0Ready, req1Ready});
        end
        testsRun++;
        if ({stall, err, owner} !== 3'b000) begin
            testsFailed++; $display("[TB] FAIL reset_flags: got stall/err/owner=%b want 000", {stall, err, owner});
        end
        tick;
        rst = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0;
    endtask

    task automatic test_basic_packet;
        req0Valid = 1'b1; req0Data = 32'hA000_0000; readyIn = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({validOut, req0Ready} !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL basic_grant_latency: got valid/rdy0=%b want 00", {validOut, req0Ready});
        end
        tick;
        for (int k = 0; k < 4; k++) begin
            req0Data = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            testsRun++;
            if ({validOut, req0Ready, req1Ready, owner} !== 4'b1100 || dataOut !== 32'hA000_0000 + 32'(k)) begin
                testsFailed++;
                $display("[TB] FAIL basic_flit%0d: got v/r0/r1/own=%b data=%h want 1100 data=%h",
                         k, {validOut, req0Ready, req1Ready, owner}, dataOut, 32'hA000_0000 + 32'(k));
            end
            testsRun++;
            if (credits !== 5'(16 - k)) begin testsFailed++; $display("[TB] FAIL basic_credits%0d: got %0d want %0d", k, credits, 16 - k); end
            tick;
        end
        req0Valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (validOut !== 1'b0 || credits !== 5'd12) begin
            testsFailed++; $display("[TB] FAIL basic_after: got valid=%b credits=%0d want 0/12", validOut, credits);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic expOwner;
        req0Valid = 1'b1; req1Valid = 1'b1; readyIn = 1'b1;
        req0Data = 32'h0000_0A0A; req1Data = 32'h0000_0B0B;
        for (int p = 0; p < 4; p++) begin
            expOwner = (p % 2 == 0) ? 1'b1 : 1'b0;
            creditUpd = '0;
            @(negedge clk);
            testsRun++;
            if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_bubble%0d: got valid=%b want 0", p, validOut); end
            tick;
            for (int f = 0; f < 4; f++) begin
                creditUpd = 32'd1;
                @(negedge clk);
                testsRun++;
                if (validOut !== 1'b1 || owner !== expOwner || {req1Ready, req0Ready} !== (expOwner ? 2'b10 : 2'b01)
                    || dataOut !== (expOwner ? 32'h0000_0B0B : 32'h0000_0A0A)) begin
                    testsFailed++;
                    $display("[TB] FAIL rr_pkt%0d_flit%0d: got valid=%b owner=%b rdy=%b%b data=%h want owner=%b",
                             p, f, validOut, owner, req1Ready, req0Ready, dataOut, expOwner);
                end
                tick;
            end
        end
        creditUpd = '0; req0Valid = 1'b0; req1Valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd12) begin testsFailed++; $display("[TB] FAIL rr_credits_net: got %0d want 12", credits); end
        tick;
    endtask

    task automatic test_credit_drain;
        req1Valid = 1'b1; req1Data = 32'hC0DE_0001; readyIn = 1'b1; creditUpd = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            testsRun++;
            if (validOut !== (i % 5 != 0)) begin
                testsFailed++; $display("[TB] FAIL drain_c%0d: got valid=%b want %b", i, validOut, (i % 5 != 0));
            end
            tick;
        end
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd0) begin testsFailed++; $display("[TB] FAIL drain_empty: got %0d want 0", credits); end
        tick;
        @(negedge clk);
        testsRun++;
        if ({validOut, req1Ready} !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL drain_gated: got valid/rdy1=%b want 00", {validOut, req1Ready});
        end
        tick;
        creditUpd = 32'd1;
        @(negedge clk);
        testsRun++;
        if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_return_cycle: got valid=%b want 0", validOut); end
        tick;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd1 || {validOut, req1Ready} !== 2'b11) begin
            testsFailed++; $display("[TB] FAIL drain_one_flit: got credits=%0d valid/rdy1=%b want 1/11", credits, {validOut, req1Ready});
        end
        tick;
        creditUpd = '0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd1 || validOut !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL drain_net_zero: got credits=%0d valid=%b want 1/1", credits, validOut);
        end
        tick;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd0 || validOut !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL drain_last: got credits=%0d valid=%b want 0/0", credits, validOut);
        end
        tick;
    endtask

    task automatic test_watchdog;
        req1Valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL wdog_pre: got stall=%b want 0", stall); end
        tick;
        req1Valid = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            testsRun++;
            if (stall !== 1'b0 || validOut !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL wdog_count%0d: got stall=%b valid=%b want 0/0", s, stall, validOut);
            end
            tick;
        end
        creditUpd = 32'd2;
        @(negedge clk);
        testsRun++;
        if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL wdog_fire: got stall=%b want 1", stall); end
        tick;
        creditUpd = '0;
        @(negedge clk);
        testsRun++;
        if (validOut !== 1'b1 || stall !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL wdog_resume: got valid=%b stall=%b want 1/1", validOut, stall);
        end
        tick;
        rst = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({validOut, req1Ready} !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL midpkt_rst_gate: got valid/rdy1=%b want 00", {validOut, req1Ready});
        end
        tick;
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd16 || stall !== 1'b0 || validOut !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL midpkt_rst_state: got credits=%0d stall=%b valid=%b want 16/0/0", credits, stall, validOut);
        end
        tick;
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            testsRun++;
            if (validOut !== 1'b1 || owner !== 1'b1) begin
                testsFailed++; $display("[TB] FAIL midpkt_full_pkt%0d: got valid=%b owner=%b want 1/1", f, validOut, owner);
            end
            tick;
        end
        req1Valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (validOut !== 1'b0 || credits !== 5'd12) begin
            testsFailed++; $display("[TB] FAIL midpkt_pkt_end: got valid=%b credits=%0d want 0/12", validOut, credits);
        end
        tick;
    endtask

    task automatic test_overflow;
        creditUpd = 32'd4;
        tick;
        creditUpd = '0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd16 || err !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL ovf_exact_max: got credits=%0d err=%b want 16/0", credits, err);
        end
        tick;
        creditUpd = 32'd3;
        tick;
        creditUpd = '0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd16 || err !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ovf_clamp: got credits=%0d err=%b want 16/1", credits, err);
        end
        tick; tick;
        @(negedge clk);
        testsRun++;
        if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_sticky: got err=%b want 1", err); end
        tick;
        creditUpd = 32'hFFFF_FFFF;
        tick;
        creditUpd = '0;
        @(negedge clk);
        testsRun++;
        if (credits !== 5'd16) begin testsFailed++; $display("[TB] FAIL ovf_wide: got credits=%0d want 16", credits); end
        tick;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_round_robin();
        test_credit_drain();
        test_watchdog();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
